// File: rtl/systolic_array_nxm.sv
// systolic_array_nxm
//   Weight-stationary ROWS x COLS systolic array for signed Q(DATA_W-FRAC_W).FRAC_W
//   data. Each input vector is skewed into the rows, multiplied against the
//   stationary weights, accumulated down each column with saturation, and
//   deskewed so that all columns emerge together ROWS+COLS-1 cycles later.
//   Each PE holds two weights. A new set is shifted into the shadow copies
//   while the active copies keep computing. A switch token travelling with
//   the data then promotes shadow to active, one PE at a time.
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   in_data carries a vector this cycle
//   in_data    ROWS words, row r at [r*DATA_W +: DATA_W]
//   in_switch  switch token; this cycle's vector already uses the new weights
//   w_shift    push w_data into the top shadow row (only while w_ready)
//   w_data     COLS words, column c at [c*DATA_W +: DATA_W]
//   w_ready    shadow weights may be shifted (no token still in flight)
//   w_loaded   ROWS shifts accepted since reset or the last switch
//   out_valid  out_data carries a result vector
//   out_data   COLS words, column c at [c*DATA_W +: DATA_W]; zero when idle
//   out_switch switch token leaving the array

module systolic_array_nxm_pe #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_v,
  input  logic              i_s,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_psum,
  input  logic [DATA_W-1:0] i_shadow,
  output logic              o_v,
  output logic              o_s,
  output logic [DATA_W-1:0] o_x,
  output logic [DATA_W-1:0] o_psum
);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW:0] SMAX = {{(DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [PW:0] SMIN = {{(DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0]    r_active;
  logic [DATA_W-1:0]    w_wt;
  logic [DATA_W-1:0]    w_sat;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_prod_sh;
  logic signed [PW:0]   w_sum;

  // The token edge both promotes the weight and uses it for the same data.
  assign w_wt      = i_s ? i_shadow : r_active;
  assign w_prod    = $signed({{DATA_W{i_x[DATA_W-1]}}, i_x}) *
                     $signed({{DATA_W{w_wt[DATA_W-1]}}, w_wt});
  assign w_prod_sh = w_prod >>> FRAC_W;
  assign w_sum     = $signed({{(DATA_W+1){i_psum[DATA_W-1]}}, i_psum}) +
                     $signed({w_prod_sh[PW-1], w_prod_sh});

  always_comb begin
    if (w_sum > SMAX)      w_sat = {1'b0, {(DATA_W-1){1'b1}}};
    else if (w_sum < SMIN) w_sat = {1'b1, {(DATA_W-1){1'b0}}};
    else                   w_sat = w_sum[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_active <= '0;
      o_v      <= 1'b0;
      o_s      <= 1'b0;
      o_x      <= '0;
      o_psum   <= '0;
    end else begin
      if (i_s) r_active <= i_shadow;
      o_v    <= i_v;
      o_s    <= i_s;
      o_x    <= i_x;
      o_psum <= i_v ? w_sat : '0;
    end
  end
endmodule

module systolic_array_nxm #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [ROWS*DATA_W-1:0] in_data,
  input  logic                   in_switch,
  input  logic                   w_shift,
  input  logic [COLS*DATA_W-1:0] w_data,
  output logic                   w_ready,
  output logic                   w_loaded,
  output logic                   out_valid,
  output logic [COLS*DATA_W-1:0] out_data,
  output logic                   out_switch
);
  localparam int L  = ROWS + COLS - 1;
  localparam int BW = $clog2(L);
  localparam int CW = $clog2(ROWS + 1);

  logic [ROWS-1:0][DATA_W-1:0]             w_in_rows;
  logic [ROWS-1:0][COLS:0][DATA_W-1:0]     w_x;
  logic [ROWS-1:0][COLS:0]                 w_v;
  logic [ROWS-1:0][COLS:0]                 w_s;
  logic [ROWS:0][COLS-1:0][DATA_W-1:0]     w_p;
  logic [COLS-1:0][DATA_W-1:0]             w_deskew;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0]   r_shadow;
  logic [BW-1:0]                           r_busy;
  logic [CW-1:0]                           r_cnt;
  logic                                    w_shift_acc;
  logic                                    w_unused;

  assign w_in_rows = in_data;

  // Row r enters the grid r cycles late so its psum meets the row above.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign w_x[0][0] = w_in_rows[0];
      assign w_v[0][0] = in_valid;
      assign w_s[0][0] = in_switch;
    end else begin : g_dly
      logic [r-1:0][DATA_W-1:0] r_d;
      logic [r-1:0]             r_dv;
      logic [r-1:0]             r_ds;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_d  <= '0;
          r_dv <= '0;
          r_ds <= '0;
        end else begin
          r_d[0]  <= w_in_rows[r];
          r_dv[0] <= in_valid;
          r_ds[0] <= in_switch;
          for (int i = 1; i < r; i++) begin
            r_d[i]  <= r_d[i-1];
            r_dv[i] <= r_dv[i-1];
            r_ds[i] <= r_ds[i-1];
          end
        end
      end
      assign w_x[r][0] = r_d[r-1];
      assign w_v[r][0] = r_dv[r-1];
      assign w_s[r][0] = r_ds[r-1];
    end
  end

  assign w_p[0] = '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      systolic_array_nxm_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_pe (
        .clk      (clk),
        .rst      (rst),
        .i_v      (w_v[r][c]),
        .i_s      (w_s[r][c]),
        .i_x      (w_x[r][c]),
        .i_psum   (w_p[r][c]),
        .i_shadow (r_shadow[r][c]),
        .o_v      (w_v[r][c+1]),
        .o_s      (w_s[r][c+1]),
        .o_x      (w_x[r][c+1]),
        .o_psum   (w_p[r+1][c])
      );
    end
  end

  // Left columns finish early; hold them until the rightmost column catches up.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign w_deskew[c] = w_p[ROWS][c];
    end else begin : g_dly
      logic [D-1:0][DATA_W-1:0] r_q;
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_q <= '0;
        end else begin
          r_q[0] <= w_p[ROWS][c];
          for (int i = 1; i < D; i++) r_q[i] <= r_q[i-1];
        end
      end
      assign w_deskew[c] = r_q[D-1];
    end
  end

  assign out_valid  = w_v[ROWS-1][COLS];
  assign out_switch = w_s[ROWS-1][COLS];
  assign out_data   = out_valid ? w_deskew : '0;

  // Outputs off the right edge of the grid that nothing consumes.
  always_comb begin
    w_unused = 1'b0;
    for (int r = 0; r < ROWS; r++)
      w_unused = w_unused ^ (^w_x[r][COLS]) ^ w_v[r][COLS] ^ w_s[r][COLS];
  end

  // Shadow may not change until the newest token has passed the last PE.
  assign w_ready     = (r_busy == '0);
  assign w_shift_acc = w_shift & w_ready & ~in_switch;
  assign w_loaded    = (r_cnt == CW'(ROWS));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy   <= '0;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      if (in_switch)          r_busy <= BW'(L - 1);
      else if (r_busy != '0)  r_busy <= r_busy - BW'(1);

      if (in_switch)                             r_cnt <= '0;
      else if (w_shift_acc && !w_loaded)         r_cnt <= r_cnt + CW'(1);

      if (w_shift_acc) begin
        r_shadow[0] <= w_data;
        for (int r = 1; r < ROWS; r++) r_shadow[r] <= r_shadow[r-1];
      end
    end
  end
endmodule

// File: tb/tb_systolic_array_nxm.sv
// tb_systolic_array_nxm
//   2x2 Q8.8 bench. The stimulus process pushes hand-computed results and
//   expected w_ready/w_loaded values into queues; the monitor on the falling
//   edge pops and compares whatever the DUT presents.
module tb_systolic_array_nxm;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_switch = 1'b0;
  logic        w_shift = 1'b0;
  logic [31:0] w_data = '0;
  logic        w_ready, w_loaded, out_valid, out_switch;
  logic [31:0] out_data;

  typedef struct { logic [31:0] data; logic vld; logic sw; int cyc; } exp_t;
  typedef struct { int cyc; logic rdy; logic ld; bit tmo; } st_t;

  exp_t q[$];
  st_t  sq[$];
  exp_t e;
  st_t  s;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  bit   done = 0;

  systolic_array_nxm #(.ROWS(2), .COLS(2), .DATA_W(16), .FRAC_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_switch  (in_switch),
    .w_shift    (w_shift),
    .w_data     (w_data),
    .w_ready    (w_ready),
    .w_loaded   (w_loaded),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_switch (out_switch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  // One cycle of stimulus; expected result lands LAT cycles later.
  task automatic drive(input bit v, input logic [31:0] d, input bit sw,
                       input bit sh, input logic [31:0] wd, input logic [31:0] ed);
    in_valid = v; in_data = d; in_switch = sw; w_shift = sh; w_data = wd;
    if (v || sw) q.push_back(exp_t'{data: (v ? ed : 32'h0), vld: v, sw: sw, cyc: cyc + LAT});
    @(posedge clk); #1;
    in_valid = 0; in_data = '0; in_switch = 0; w_shift = 0; w_data = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic status(input bit rdy, input bit ld);
    sq.push_back(st_t'{cyc: cyc, rdy: rdy, ld: ld, tmo: 0});
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!w_ready && n < 20) begin idle(1); n++; end
    if (!w_ready) sq.push_back(st_t'{cyc: cyc, rdy: 1, ld: 0, tmo: 1});
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      n_vec++;
      if (out_valid || out_switch) begin
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out cyc=%0d got valid=%b sw=%b data=%h, required no output",
                   cyc, out_valid, out_switch, out_data);
        end else begin
          e = q.pop_front();
          if (out_data !== e.data || out_valid !== e.vld || out_switch !== e.sw || cyc != e.cyc) begin
            n_err++;
            $display("FAIL result cyc=%0d got valid=%b sw=%b data=%h, required cyc=%0d valid=%b sw=%b data=%h",
                     cyc, out_valid, out_switch, out_data, e.cyc, e.vld, e.sw, e.data);
          end
        end
      end else if (out_data !== 32'h0) begin
        n_err++;
        $display("FAIL idle_data cyc=%0d got %h, required 00000000", cyc, out_data);
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        s = sq.pop_front();
        n_vec++;
        if (s.tmo) begin
          n_err++;
          $display("FAIL ready_timeout cyc=%0d got w_ready=%b, required 1", cyc, w_ready);
        end else if (w_ready !== s.rdy || w_loaded !== s.ld) begin
          n_err++;
          $display("FAIL status cyc=%0d got w_ready=%b w_loaded=%b, required w_ready=%b w_loaded=%b",
                   cyc, w_ready, w_loaded, s.rdy, s.ld);
        end
      end
      if (done) begin
        n_vec++;
        if (q.size() != 0) begin
          n_err++;
          $display("FAIL missing_out got %0d results outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    mon_en = 1;
    status(1, 0);
    @(posedge clk); #1;
    rst = 1;
    status(1, 0);

    // Identity: bottom row {W11=0,W10=1}, top row {W01=1,W00=0}
    drive(0, 32'h0, 0, 1, 32'h0000_0100, 32'h0); status(1, 0);
    drive(0, 32'h0, 0, 1, 32'h0100_0000, 32'h0); status(1, 1);
    // Switch + vector; the shift in the same cycle must be ignored
    drive(1, 32'h0200_0300, 1, 1, 32'h7FFF_7FFF, 32'h0300_0200);
    status(0, 0);
    drive(0, 32'h0, 0, 1, 32'h7FFF_7FFF, 32'h0);   // ignored: busy
    status(0, 0);
    idle(1);
    status(1, 0);

    // Shadow untouched by the ignored shifts; bubble switch restarts window
    drive(1, 32'h0100_0200, 1, 0, 32'h0, 32'h0200_0100);
    drive(0, 32'h0, 1, 0, 32'h0, 32'h0);
    status(0, 0);
    idle(1);
    status(0, 0);
    idle(1);
    status(1, 0);

    // Saturation, all weights 2.0
    drive(0, 32'h0, 0, 1, 32'h0200_0200, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h0200_0200, 32'h0);
    status(1, 1);
    drive(1, 32'h4000_4000, 1, 0, 32'h0, 32'h7FFF_7FFF);
    drive(1, 32'hC000_C000, 0, 0, 32'h0, 32'h8000_8000);

    // Streaming switch: new shadow all 0.5, switch rides on vector 3
    wait_ready();
    drive(0, 32'h0, 0, 1, 32'h0080_0080, 32'h0);
    drive(0, 32'h0, 0, 1, 32'h0080_0080, 32'h0);
    status(1, 1);
    drive(1, 32'h0100_0100, 0, 0, 32'h0, 32'h0400_0400);
    drive(1, 32'h0100_0080, 0, 0, 32'h0, 32'h0300_0300);
    drive(1, 32'h0200_0400, 1, 0, 32'h0, 32'h0300_0300);
    drive(1, 32'h0000_FFFF, 0, 0, 32'h0, 32'hFFFF_FFFF);  // floor: -1/256*0.5 -> -1/256
    idle(5);

    // Reset with two vectors in flight: they must never appear
    drive(1, 32'h1234_1234, 0, 0, 32'h0, 32'h0);
    drive(1, 32'h1111_2222, 0, 0, 32'h0, 32'h0);
    rst = 0;
    q.delete();
    @(posedge clk); #1;
    rst = 1;
    status(1, 0);
    idle(4);

    // Fresh weights: W10=1,W11=3 then W00=2,W01=-1; in {1,1} -> col0=3, col1=2
    drive(0, 32'h0, 0, 1, 32'h0300_0100, 32'h0);
    drive(0, 32'h0, 0, 1, 32'hFF00_0200, 32'h0);
    status(1, 1);
    drive(1, 32'h0100_0100, 1, 0, 32'h0, 32'h0200_0300);

    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    done = 1;
  end
endmodule
